// File: rtl/min_stream_sched.sv
// Streaming minimum finder: walks a framed word stream through one compare-select per beat
// and presents the frame minimum, its first index and the beat count on a valid/ready port.
module min_stream_sched #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_min,
   output logic [IDX_W-1:0] out_idx,
   output logic [IDX_W:0]   out_count,
   output logic             out_ovf
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam logic [IDX_W:0] COUNT_MAX = {1'b1, {IDX_W{1'b0}}};
   localparam logic [IDX_W:0] COUNT_ONE = {{IDX_W{1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [WIDTH-1:0] min_q, min_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W:0]   count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic             accept;
   logic             at_max;

   assign in_ready  = (state != HOLD) && !abort;
   assign accept    = in_valid && in_ready;
   assign at_max    = (count_q == COUNT_MAX);

   assign out_valid = valid_q;
   assign out_min   = min_q;
   assign out_idx   = idx_q;
   assign out_count = count_q;
   assign out_ovf   = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         min_q   <= '0;
         idx_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         min_q   <= min_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   // Abort wins over every handshake; result registers keep their last values.
   always_comb begin
      state_nxt = state;
      min_d     = min_q;
      idx_d     = idx_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      valid_d   = valid_q;
      if (abort) begin
         state_nxt = IDLE;
         valid_d   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  min_d     = in_data;
                  idx_d     = '0;
                  count_d   = COUNT_ONE;
                  ovf_d     = 1'b0;
                  state_nxt = in_last ? HOLD : ACCUM;
                  valid_d   = in_last;
               end
            end
            ACCUM: begin
               if (accept) begin
                  // Beats past the indexable range still compete for the minimum
                  // but leave the index at its last representable position.
                  if (in_data < min_q) begin
                     min_d = in_data;
                     if (!at_max) idx_d = count_q[IDX_W-1:0];
                  end
                  if (at_max) ovf_d = 1'b1;
                  else        count_d = count_q + 1'b1;
                  if (in_last) begin
                     state_nxt = HOLD;
                     valid_d   = 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  valid_d   = 1'b0;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_min_stream_sched.sv
// Directed bench for min_stream_sched: a default-width instance (a_*) and a 2-bit-index
// instance (b_*) for overflow; expected results are queued per frame and popped at output.
module tb_min_stream_sched;

   localparam int IDXA = 16;
   localparam int IDXB = 2;

   typedef struct {
      logic [31:0] mn;
      logic [15:0] idx;
      logic [16:0] cnt;
      logic        ovf;
   } result_t;

   logic clk;
   logic rst_n;
   logic abort;
   logic in_valid;
   logic in_valid_b;
   logic [31:0] in_data;
   logic in_last;
   logic out_ready;
   logic out_ready_b;

   logic             a_in_ready, a_out_valid, a_out_ovf;
   logic [31:0]      a_out_min;
   logic [IDXA-1:0]  a_out_idx;
   logic [IDXA:0]    a_out_count;
   logic             b_in_ready, b_out_valid, b_out_ovf;
   logic [31:0]      b_out_min;
   logic [IDXB-1:0]  b_out_idx;
   logic [IDXB:0]    b_out_count;

   logic [31:0] frameWords[$];
   result_t     sb[$];
   int checks = 0;
   int passes = 0;
   int fails  = 0;

   min_stream_sched #(.WIDTH(32), .IDX_W(IDXA)) dutA (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_min(a_out_min),
      .out_idx(a_out_idx), .out_count(a_out_count), .out_ovf(a_out_ovf)
   );

   min_stream_sched #(.WIDTH(32), .IDX_W(IDXB)) dutB (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .in_valid(in_valid_b), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(b_out_valid), .out_ready(out_ready_b), .out_min(b_out_min),
      .out_idx(b_out_idx), .out_count(b_out_count), .out_ovf(b_out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model of one closed frame for an instance with the given index width.
   task automatic pushExpected(input int idxw);
      result_t r;
      int n;
      int lim;
      n     = frameWords.size();
      lim   = 1 << idxw;
      r.mn  = frameWords[0];
      r.idx = '0;
      for (int i = 1; i < n; i++) begin
         if (frameWords[i] < r.mn) begin
            r.mn = frameWords[i];
            if (i < lim) r.idx = 16'(i);
         end
      end
      r.cnt = (n > lim) ? 17'(lim) : 17'(n);
      r.ovf = (n > lim);
      sb.push_back(r);
   endtask

   task automatic applyStimulus(input bit useB, input bit closeFrame);
      int n;
      bit acc;
      int waitCnt;
      n = frameWords.size();
      for (int i = 0; i < n; i++) begin
         acc     = 1'b0;
         waitCnt = 0;
         in_data = frameWords[i];
         in_last = closeFrame && (i == n - 1);
         if (useB) in_valid_b = 1'b1;
         else      in_valid   = 1'b1;
         #1;
         while (!acc && waitCnt < 20) begin
            acc = useB ? b_in_ready : a_in_ready;
            @(posedge clk);
            #1;
            waitCnt++;
         end
         if (!acc) begin
            checks++;
            fails++;
            $error("[TB] FAIL accept_timeout: observed in_ready=0 for %0d cycles expected 1", waitCnt);
         end
      end
      in_valid   = 1'b0;
      in_valid_b = 1'b0;
      in_last    = 1'b0;
      if (closeFrame) pushExpected(useB ? IDXB : IDXA);
   endtask

   task automatic compareResult(input bit useB, input string tag);
      result_t e;
      if (sb.size() == 0) begin
         checks++;
         fails++;
         $error("[TB] FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      end else begin
         e = sb.pop_front();
         if (useB) begin
            chk({tag, "_min"},   b_out_min,   e.mn);
            chk({tag, "_idx"},   b_out_idx,   e.idx);
            chk({tag, "_count"}, b_out_count, e.cnt);
            chk({tag, "_ovf"},   b_out_ovf,   e.ovf);
         end else begin
            chk({tag, "_min"},   a_out_min,   e.mn);
            chk({tag, "_idx"},   a_out_idx,   e.idx);
            chk({tag, "_count"}, a_out_count, e.cnt);
            chk({tag, "_ovf"},   a_out_ovf,   e.ovf);
         end
      end
   endtask

   // Called one cycle after the in_last beat was taken: result must already be up.
   task automatic checkOutput(input bit useB, input string tag);
      chk({tag, "_valid"},    useB ? b_out_valid : a_out_valid, 1);
      chk({tag, "_inready"},  useB ? b_in_ready  : a_in_ready,  0);
      compareResult(useB, tag);
      if (useB ? out_ready_b : out_ready) begin
         step();
         chk({tag, "_valid_drop"}, useB ? b_out_valid : a_out_valid, 0);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      abort       = 1'b0;
      in_valid    = 1'b0;
      in_valid_b  = 1'b0;
      in_data     = '0;
      in_last     = 1'b0;
      out_ready   = 1'b1;
      out_ready_b = 1'b1;
      #2;
      chk("rst_valid", a_out_valid, 0);
      chk("rst_min",   a_out_min,   0);
      chk("rst_idx",   a_out_idx,   0);
      chk("rst_count", a_out_count, 0);
      chk("rst_ovf",   a_out_ovf,   0);
      #10;
      rst_n = 1'b1;
      step();
      chk("rst_inready", a_in_ready, 1);

      $display("[TB] basic frame");
      frameWords = {32'h10, 32'h5, 32'hFFFF_FFFF, 32'h7};
      applyStimulus(0, 1);
      checkOutput(0, "t1");

      $display("[TB] tie and single beat");
      frameWords = {32'h9, 32'h3, 32'h3};
      applyStimulus(0, 1);
      checkOutput(0, "t2a");
      frameWords = {32'h0};
      applyStimulus(0, 1);
      checkOutput(0, "t2b");

      $display("[TB] backpressure");
      out_ready  = 1'b0;
      frameWords = {32'h100, 32'h50};
      applyStimulus(0, 1);
      in_data  = 32'h77;
      in_last  = 1'b1;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk("t3_hold_valid",   a_out_valid, 1);
         chk("t3_hold_inready", a_in_ready,  0);
         chk("t3_hold_min",     a_out_min,   32'h50);
         step();
      end
      compareResult(0, "t3");
      frameWords = {32'h77};
      pushExpected(IDXA);
      out_ready = 1'b1;
      step();
      chk("t3_release_valid",   a_out_valid, 0);
      chk("t3_release_inready", a_in_ready,  1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      checkOutput(0, "t3b");

      $display("[TB] abort");
      frameWords = {32'h20, 32'h1};
      applyStimulus(0, 0);
      chk("t4_count_pre", a_out_count, 2);
      in_valid = 1'b1;
      in_data  = 32'h99;
      abort    = 1'b1;
      #1;
      chk("t4_abort_inready", a_in_ready, 0);
      step();
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("t4_valid_after", a_out_valid, 0);
      step();
      chk("t4_valid_after2", a_out_valid, 0);
      frameWords = {32'h40};
      applyStimulus(0, 1);
      checkOutput(0, "t4");

      $display("[TB] overflow on narrow index");
      frameWords = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2};
      applyStimulus(1, 1);
      checkOutput(1, "t5");
      frameWords = {32'd9};
      applyStimulus(1, 1);
      checkOutput(1, "t5b");

      $display("[TB] async reset mid-frame");
      frameWords = {32'h30, 32'h31};
      applyStimulus(0, 0);
      chk("t6_count_pre", a_out_count, 2);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_valid", a_out_valid, 0);
      chk("t6_min",   a_out_min,   0);
      chk("t6_count", a_out_count, 0);
      chk("t6_idx",   a_out_idx,   0);
      #2;
      rst_n = 1'b1;
      step();
      chk("t6_inready", a_in_ready, 1);
      frameWords = {32'hA};
      applyStimulus(0, 1);
      checkOutput(0, "t6");

      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/min_stream_sched.md
Name: min_stream_sched

Overview:
- Sequencer for the shared 32-bit unsigned compare-select (minimum) datapath.
- Accepts a stream of words framed by in_last with valid/ready handshake.
- Steps each accepted word through one compare-select against the running minimum per cycle.
- Returns the frame minimum, its beat index and the beat count on a valid/ready result port; sits between a producer FIFO and the downstream selection logic in the FHE-optimised comparator pipeline.

Parameters:
WIDTH, 32, data word width (unsigned compare)
IDX_W, 16, width of beat index; frames up to 2^IDX_W beats are fully indexed

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
abort  input  1  synchronous frame abort, active high
in_valid  input  1  input word valid
in_ready  output  1  block can accept input word
in_data  input  WIDTH  input word
in_last  input  1  final word of frame
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_min  output  WIDTH  minimum of frame
out_idx  output  IDX_W  index (0-based) of first occurrence of minimum
out_count  output  IDX_W+1  number of beats in frame (saturating)
out_ovf  output  1  frame exceeded 2^IDX_W beats

Behaviour:
- Clock/reset: one clock clk; reset rst_n asynchronous, active-low.
- Reset: state=IDLE; out_valid=0; out_min, out_idx, out_count, out_ovf all 0. Internal min/idx/count registers 0. in_ready=1 once rst_n deasserted.
- Accept: a beat is taken when in_valid & in_ready on a rising edge. Output registers change only on acceptance, abort or reset.
- States: IDLE, ACCUM, HOLD. in_ready=1 in IDLE and ACCUM, 0 in HOLD; in_ready=0 in any cycle with abort=1.
- IDLE, beat accepted:
  - min<=in_data, idx<=0, count<=1, ovf<=0.
  - in_last=1 -> HOLD, else ACCUM.
- ACCUM, beat accepted:
  - If in_data < min (strict unsigned): min<=in_data, idx<=count[IDX_W-1:0].
  - count<=count+1; then in_last=1 -> HOLD.
- Ties: equal values never replace; out_idx is the earliest occurrence.
- Overflow: a beat accepted while count==2^IDX_W sets ovf=1 (sticky until next frame start).
  - count holds at 2^IDX_W.
  - min still updates; idx does not update for such beats.
- HOLD:
  - out_valid=1; out_min/out_idx/out_count/out_ovf stable.
  - out_ready=1 -> out_valid<=0, state<=IDLE.
  - Earliest next-frame acceptance is the cycle after the handshake (no overlap).
- Latency: out_valid rises on the edge that accepts the in_last beat (visible next cycle). Single-beat frame: result 1 cycle after the beat.
- Throughput: 1 word/cycle in ACCUM. Frame of N beats plus result handshake occupies >=N+1 cycles.
- abort=1 (priority over all handshakes in same cycle):
  - state<=IDLE, out_valid<=0.
  - Partial frame or pending result discarded.
  - Output data registers hold their last values (don't-care while out_valid=0).
- Reset mid-frame or mid-HOLD: immediate return to reset values; no result emitted.
- in_valid with in_ready=0: beat is not consumed; the producer must hold it.
- No output combinationally depends on in_data; in_ready depends only on state and abort.

Test Plan:
1. Frame {0x00000010, 0x00000005, 0xFFFFFFFF, 0x00000007}, in_last on 4th, out_ready=1 -> one result: out_min=0x5, out_idx=1, out_count=4, out_ovf=0; out_valid high exactly 1 cycle.
2. Tie and single-beat: frame {0x9, 0x3, 0x3} -> min 0x3, idx 1, count 3. Then single beat 0x0 with in_last -> min 0x0, idx 0, count 1, out_valid the cycle after acceptance.
3. Backpressure: out_ready=0 for 5 cycles after result.
   - out_valid and outputs stable; in_ready=0; next frame's in_valid not consumed.
   - out_ready=1 -> IDLE; next frame accepted the following cycle.
4. Abort: frame {0x20, 0x1} then abort=1 with in_valid=1 (no in_last).
   - No result; that beat not consumed.
   - Next frame {0x40} -> min 0x40, idx 0, count 1.
5. Overflow with IDX_W=2: frame of 6 beats {7,6,5,4,3,2}:
   - min=2, idx=3 (last indexable update was value 4 at idx 3), count=4, ovf=1.
   - Next frame clears ovf.
6. Async reset:
   - Assert rst_n=0 mid-ACCUM, between edges -> out_valid=0 and outputs 0 immediately.
   - After release, in_ready=1; fresh frame {0xA} -> min 0xA.
